// File: rtl/raise_feeder.sv
// rtl/raise_feeder.sv - ping-pong FFT frame buffer and bin-pair dispatcher for the frequency-raise stage
// Optional feature macro: RAISE_FEED_TIMEOUT_EN (bounded WAIT with sticky err flag)
module raise_feeder #(
  parameter int WIDTH   = 32,
  parameter int NBINS   = 64,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] fft1_data,
  output logic [WIDTH-1:0] fft2_data,
  output logic [5:0]       freq,
  output logic             fft_valid,
  input  logic             raise_fin,
  output logic             frame_done,
  output logic             err
);

  localparam logic [5:0] LAST_BIN = 6'(NBINS - 1);

  typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [5:0]       wptr_q, wptr_d;
  logic [5:0]       k_q, k_d;
  logic             primed_q, primed_d;
  logic             fin_q, fin_d;
  logic [WIDTH-1:0] fft1_q, fft1_d;
  logic [WIDTH-1:0] fft2_q, fft2_d;
  logic [5:0]       freq_q, freq_d;
  logic             wr_en;
  logic             rise;
  logic             timeout_hit;

  // Frame storage is data-only, so it carries no reset.
  logic [WIDTH-1:0] bank0_mem [NBINS];
  logic [WIDTH-1:0] bank1_mem [NBINS];

  assign rise = raise_fin & ~fin_q;

`ifdef RAISE_FEED_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // A WAIT lasting TIMEOUT cycles without an edge is treated as a completed bin.
  assign timeout_hit = (state_q == S_WAIT) && !rise && (cnt_q == 8'(TIMEOUT - 1));
  assign err         = err_q;

  // Counter clears while issuing (i.e. on entry to WAIT) and counts WAIT cycles.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | timeout_hit;
    if (state_q == S_ISSUE) begin
      cnt_d = 8'd0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Timeout counter and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Next-state logic: capture frames, then walk bins handshaking on raise_fin edges.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    wptr_d   = wptr_q;
    k_d      = k_q;
    primed_d = primed_q;
    fin_d    = raise_fin;
    fft1_d   = fft1_q;
    fft2_d   = fft2_q;
    freq_d   = freq_q;
    wr_en    = 1'b0;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 6'd1;
          if (wptr_q == LAST_BIN) begin
            wptr_d = 6'd0;
            if (!primed_q) begin
              primed_d = 1'b1;
              sel_d    = ~sel_q;
            end else begin
              k_d     = 6'd0;
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (rise || timeout_hit) begin
          if (k_q == LAST_BIN) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 6'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        // Next frame overwrites the oldest bank.
        sel_d   = ~sel_q;
        wptr_d  = 6'd0;
        state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
    // Output pair is latched on entry to ISSUE and held until the next one.
    if (state_d == S_ISSUE) begin
      fft1_d = sel_q ? bank0_mem[k_d] : bank1_mem[k_d];
      fft2_d = sel_q ? bank1_mem[k_d] : bank0_mem[k_d];
      freq_d = k_d;
    end
  end

  // Bank write port: the bank selected by sel receives the incoming bin.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (sel_q) bank1_mem[wptr_q] <= in_data;
      else       bank0_mem[wptr_q] <= in_data;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FILL;
      sel_q    <= 1'b0;
      wptr_q   <= 6'd0;
      k_q      <= 6'd0;
      primed_q <= 1'b0;
      fin_q    <= 1'b0;
      fft1_q   <= '0;
      fft2_q   <= '0;
      freq_q   <= 6'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      wptr_q   <= wptr_d;
      k_q      <= k_d;
      primed_q <= primed_d;
      fin_q    <= fin_d;
      fft1_q   <= fft1_d;
      fft2_q   <= fft2_d;
      freq_q   <= freq_d;
    end
  end

  assign in_ready   = (state_q == S_FILL);
  assign fft_valid  = (state_q == S_ISSUE);
  assign frame_done = (state_q == S_DONE);
  assign fft1_data  = fft1_q;
  assign fft2_data  = fft2_q;
  assign freq       = freq_q;

endmodule
